seq_stream_ctrl: RTL and testbench

Frame-level controller for the serial pattern detector. Accepts parallel words over a valid/ready port, serializes them MSB-first into the detector one bit per enabled cycle, and clears the detector at the start of each frame. It counts detector hits across the frame and returns the count through a result handshake. It sits between the word-oriented host logic and any single-bit sequence detector (e.g. the 10101 FSM).

---
 rtl/seq_stream_ctrl.sv | 152 +++++++++++++++
 tb/tb_seq_stream_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: frame controller in front of a bit-serial sequence detector.
// Serializes words MSB-first, clears the detector per frame and returns the frame's hit count.
module seq_stream_ctrl #(
    parameter int W       = 8,
    parameter int HIT_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     s_data,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             ser_bit,
    output logic             ser_en,
    output logic             det_clr,
    input  logic             det_hit,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_sat,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);
    localparam int IDX_W = $clog2(W);
    localparam logic [1:0] DRAIN_INIT = (HIT_LAT > 0) ? 2'(HIT_LAT - 1) : 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_SHIFT, ST_WAIT, ST_DRAIN, ST_REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       shreg_q, shreg_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         drain_q, drain_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               hit_qual;
    logic               bit0;
    logic               load;

    assign bit0 = (idx_q == '0);
    assign load = s_ready && s_valid;

    // det_hit only counts on the cycle that answers a bit actually fed to the detector.
    generate
        if (HIT_LAT == 0) begin : g_no_pipe
            assign hit_qual = ser_en;
        end else begin : g_pipe
            logic [HIT_LAT-1:0] pipe_q, pipe_d;
            always_comb begin
                pipe_d    = pipe_q << 1;
                pipe_d[0] = ser_en;
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) pipe_q <= '0;
                else     pipe_q <= pipe_d;
            end
            assign hit_qual = pipe_q[HIT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            drain_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (s_valid) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (bit0) begin
                    if (last_q)        state_d = (HIT_LAT == 0) ? ST_REPORT : ST_DRAIN;
                    else if (!s_valid) state_d = ST_WAIT;
                end
            end
            ST_WAIT:   if (s_valid) state_d = ST_SHIFT;
            ST_DRAIN:  if (drain_q == '0) state_d = ST_REPORT;
            ST_REPORT: if (res_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        ser_en    = 1'b0;
        ser_bit   = 1'b0;
        det_clr   = 1'b0;
        res_valid = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:   s_ready = 1'b1;
            ST_CLEAR:  det_clr = 1'b1;
            ST_SHIFT: begin
                ser_en  = 1'b1;
                ser_bit = shreg_q[W-1];
                s_ready = bit0 && !last_q;
            end
            ST_WAIT:   s_ready = 1'b1;
            ST_REPORT: res_valid = 1'b1;
            default: ;
        endcase
    end

    assign res_cnt = cnt_q;
    assign res_sat = sat_q;

    always_comb begin
        shreg_d = shreg_q;
        last_d  = last_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (load) begin
            shreg_d = s_data;
            last_d  = s_last;
            idx_d   = IDX_W'(W - 1);
        end else if (ser_en) begin
            shreg_d = shreg_q << 1;
            idx_d   = idx_q - 1'b1;
        end
        if (state_q == ST_SHIFT && bit0 && last_q)
            drain_d = DRAIN_INIT;
        else if (state_q == ST_DRAIN)
            drain_d = drain_q - 1'b1;
        if (state_q == ST_CLEAR) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (hit_qual && det_hit) begin
            if (&cnt_q) sat_d = 1'b1;
            else        cnt_d = cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench for seq_stream_ctrl driving an overlapping 10101 detector model (registered output).
module tb_seq_stream_ctrl;
    localparam int W = 8, HIT_LAT = 1, CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 0, rst = 0;
    logic [W-1:0] s_data = '0;
    logic s_last = 0, s_valid = 0, s_ready;
    logic ser_bit, ser_en, det_clr, det_hit;
    logic [CNT_W-1:0] res_cnt;
    logic res_sat, res_valid, busy;
    logic res_ready = 0;

    seq_stream_ctrl #(.W(W), .HIT_LAT(HIT_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
        .s_ready(s_ready), .ser_bit(ser_bit), .ser_en(ser_en), .det_clr(det_clr),
        .det_hit(det_hit), .res_cnt(res_cnt), .res_sat(res_sat), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // detector model; noise is injected only where the controller has no bit in flight
    logic [4:0] hist = '0;
    bit noise = 0;
    always @(posedge clk) begin
        if (det_clr)     hist <= '0;
        else if (ser_en) hist <= {hist[3:0], ser_bit};
    end
    assign det_hit = (hist == 5'b10101) | (noise & (!busy | res_valid | det_clr));

    typedef struct { int cnt; int sat; int nbits; int gaps; } exp_t;
    exp_t resq[$];
    bit   bitq[$];
    int   n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ser_en"}, ser_en, 0);
        chk({tag, "_ser_bit"}, ser_bit, 0);
        chk({tag, "_det_clr"}, det_clr, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_cnt"}, res_cnt, 0);
        chk({tag, "_res_sat"}, res_sat, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_s_ready"}, s_ready, 1);
    endtask

    // Reference: count overlapping 10101 in the frame's MSB-first bit string.
    function automatic void ref_frame(input logic [7:0] wq[$], output exp_t e);
        bit b[$];
        int hits = 0;
        foreach (wq[i]) for (int k = 7; k >= 0; k--) b.push_back(wq[i][k]);
        for (int i = 0; i + 4 < b.size(); i++)
            if (b[i] && !b[i+1] && b[i+2] && !b[i+3] && b[i+4]) hits++;
        e.cnt   = (hits > CMAX) ? CMAX : hits;
        e.sat   = (hits > CMAX) ? 1 : 0;
        e.nbits = b.size();
        e.gaps  = 0;
    endfunction

    // gap = number of WAIT cycles requested before this word (0 = word already waiting)
    task automatic send_word(input logic [7:0] d, input bit l, input int gap);
        int n;
        if (gap > 0) begin
            s_valid = 0;
            n = 0;
            while (!s_ready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) fail("gap_sync_timeout");
            repeat (gap) @(negedge clk);
        end
        s_data = d; s_last = l; s_valid = 1;
        n = 0;
        while (!s_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail("accept_timeout");
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] wq[$], input int gq[$]);
        exp_t e;
        ref_frame(wq, e);
        for (int i = 1; i < wq.size(); i++) e.gaps += gq[i];
        resq.push_back(e);
        foreach (wq[i]) for (int k = 7; k >= 0; k--) bitq.push_back(wq[i][k]);
        for (int i = 0; i < wq.size(); i++)
            send_word(wq[i], (i == wq.size() - 1), (i == 0) ? 0 : gq[i]);
        s_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((resq.size() != 0 || bitq.size() != 0 || busy) && n < 3000) begin
            @(negedge clk); n++;
        end
        if (n >= 3000) fail("idle_timeout");
    endtask

    // monitor + result-ready driver
    int  cyc = 0, last_en_cyc = 0, nbits_seen = 0, gaps_seen = 0, pending = 0;
    int  hold_ctr = 0, hold_target = 0, reports = 0;
    bit  in_frame = 0, seen_bit = 0, prev_clr = 0, prev_valid = 0, prev_hs = 0;
    exp_t cur;
    always @(negedge clk) begin
        noise = 1'($urandom_range(0, 1));
        if (rst) begin
            in_frame = 0; seen_bit = 0; prev_clr = 0; prev_valid = 0; prev_hs = 0;
            res_ready = 0; hold_ctr = 0;
        end else begin
            cyc++;
            if (prev_clr) chk("first_bit_after_clr", ser_en, 1);
            if (prev_hs) begin
                chk("idle_after_release", busy, 0);
                chk("s_ready_after_release", s_ready, 1);
            end
            if (ser_en) begin
                if (bitq.size() == 0) fail("unexpected_ser_en");
                else chk("ser_bit", ser_bit, int'(bitq.pop_front()));
                if (seen_bit) gaps_seen += pending;
                pending = 0; seen_bit = 1; nbits_seen++; last_en_cyc = cyc;
            end else if (seen_bit) pending++;
            if (det_clr) begin
                in_frame = 1; seen_bit = 0; nbits_seen = 0; gaps_seen = 0; pending = 0;
            end
            if (res_valid && !prev_valid) begin
                if (resq.size() == 0) fail("unexpected_res_valid");
                else begin
                    cur = resq.pop_front();
                    chk("res_cnt", res_cnt, cur.cnt);
                    chk("res_sat", res_sat, cur.sat);
                    chk("frame_bits", nbits_seen, cur.nbits);
                    chk("frame_gap_cycles", gaps_seen, cur.gaps);
                    chk("res_latency", cyc - last_en_cyc, HIT_LAT + 1);
                    chk("clr_seen", in_frame, 1);
                end
                in_frame = 0;
                hold_target = (reports < 3) ? 5 : int'($urandom_range(0, 4));
                hold_ctr = 0;
                reports++;
            end
            if (res_valid) begin
                chk("hold_res_cnt", res_cnt, cur.cnt);
                chk("hold_res_sat", res_sat, cur.sat);
                chk("hold_s_ready", s_ready, 0);
            end
            prev_clr = det_clr;
            prev_valid = res_valid;
            if (res_valid) begin
                if (hold_ctr < hold_target) begin res_ready = 0; hold_ctr++; end
                else res_ready = 1;
            end else res_ready = 0;
            prev_hs = res_valid && res_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    logic [7:0] wq[$];
    int gq[$];
    logic [7:0] w;
    int nw;
    initial begin
        #1 rst = 1;
        #3 check_reset_vals("reset");
        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);

        wq = '{8'hAA};             gq = '{0};       run_frame(wq, gq);
        wq = '{8'hAA, 8'hAA};      gq = '{0, 0};    run_frame(wq, gq);
        wq = '{8'h00};             gq = '{0};       run_frame(wq, gq);
        wq = '{8'h0A, 8'hA0};      gq = '{0, 3};    run_frame(wq, gq);
        wq = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        gq = '{0, 0, 0, 0, 0, 0};                   run_frame(wq, gq);
        wq = '{8'h00};             gq = '{0};       run_frame(wq, gq);
        wait_idle();

        // reset during bit 4 of the first word
        s_data = 8'hAA; s_last = 1; s_valid = 1;
        for (int k = 7; k >= 0; k--) bitq.push_back(s_data[k]);
        @(posedge clk);
        #1 s_valid = 0;
        repeat (4) @(posedge clk);
        #2 chk("pre_rst_ser_en", ser_en, 1);
        rst = 1;
        #1 check_reset_vals("mid_rst");
        bitq.delete();
        repeat (3) @(negedge clk) chk("rst_hold_res_valid", res_valid, 0);
        @(posedge clk);
        #2 rst = 0;
        repeat (3) @(negedge clk) begin
            chk("post_rst_det_clr", det_clr, 0);
            chk("post_rst_res_valid", res_valid, 0);
        end
        wq = '{8'hAA};             gq = '{0};       run_frame(wq, gq);

        for (int f = 0; f < 40; f++) begin
            wq.delete(); gq.delete();
            nw = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++) begin
                case ($urandom_range(0, 3))
                    0:       w = 8'($urandom);
                    1:       w = 8'hAA;
                    2:       w = 8'h55;
                    default: w = 8'hAA ^ (8'd1 << $urandom_range(0, 7));
                endcase
                wq.push_back(w);
                gq.push_back(($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)));
            end
            run_frame(wq, gq);
        end
        wait_idle();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
